adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder.sv | 89 ++++++++
 tb/tb_adder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Registered two's-complement adder built on a two-level carry-lookahead tree.
// WIDTH must be a multiple of 16: 4-bit groups, and blocks of four groups.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             overflow
);

  localparam int NG = WIDTH / 4;
  localparam int NB = NG / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH:0]   c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG-1:0]    cg;
  logic             ovf_next;

  always_comb begin
    logic blk_c;
    g  = A & B;
    p  = A ^ B;
    gg = '0;
    gp = '0;
    cg = '0;
    c  = '0;

    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | ((&p[4*j+1 +: 3]) & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end

    // Second level: lookahead over four groups; block carries chain between blocks.
    blk_c = 1'b0;
    for (int k = 0; k < NB; k++) begin
      cg[4*k]   = blk_c;
      cg[4*k+1] = gg[4*k] | (gp[4*k] & blk_c);
      cg[4*k+2] = gg[4*k+1]
                | (gp[4*k+1] & gg[4*k])
                | (gp[4*k+1] & gp[4*k] & blk_c);
      cg[4*k+3] = gg[4*k+2]
                | (gp[4*k+2] & gg[4*k+1])
                | (gp[4*k+2] & gp[4*k+1] & gg[4*k])
                | ((&gp[4*k +: 3]) & blk_c);
      blk_c     = gg[4*k+3]
                | (gp[4*k+3] & gg[4*k+2])
                | (gp[4*k+3] & gp[4*k+2] & gg[4*k+1])
                | ((&gp[4*k+1 +: 3]) & gg[4*k])
                | ((&gp[4*k +: 4]) & blk_c);
    end

    for (int j = 0; j < NG; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & cg[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | ((&p[4*j +: 3]) & cg[j]);
    end
    c[WIDTH] = gg[NG-1] | (gp[NG-1] & cg[NG-1]);

    s_next   = p ^ c[WIDTH-1:0];
    ovf_next = c[WIDTH-1] ^ c[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S        <= '0;
      overflow <= 1'b0;
    end else begin
      S        <= s_next;
      overflow <= ovf_next;
    end
  end

endmodule

// File: tb/tb_adder.sv
// Bench for the registered lookahead adder: directed corner sums, reset
// behaviour, and a long back-to-back random stream against a reference model.
module tb_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] S;
  logic        overflow;

  int tests;
  int fails;
  logic [32:0] sbq[$];

  adder #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .S        (S),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {overflow, sum}; signed overflow from operand and result signs.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sum;
    logic        ovf;
    sum = a + b;
    ovf = (a[31] == b[31]) && (sum[31] != a[31]);
    return {ovf, sum};
  endfunction

  // Present operands for one edge, then return 1 ns after that edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic rst);
    @(negedge clk);
    A     = a;
    B     = b;
    rst_n = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [32:0] exp;
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(33'd0);
      drive($urandom, $urandom, 1'b0);
      exp = sbq.pop_front();
      tests++;
      if ({overflow, S} !== exp) begin
        fails++;
        $display("FAIL reset[%0d]: got S=%h ovf=%b, want S=%h ovf=%b",
                 i, S, overflow, exp[31:0], exp[32]);
      end
    end
  endtask

  task automatic test_directed;
    logic [31:0] ta [7];
    logic [31:0] tb [7];
    logic [32:0] te [7];
    logic [32:0] exp;
    ta[0] = 32'h80000000; tb[0] = 32'h80000000; te[0] = {1'b1, 32'h00000000};
    ta[1] = 32'h80000000; tb[1] = 32'h00000007; te[1] = {1'b0, 32'h80000007};
    ta[2] = 32'h80000008; tb[2] = 32'h00000007; te[2] = {1'b0, 32'h8000000F};
    ta[3] = 32'h8000000A; tb[3] = 32'h00000007; te[3] = {1'b0, 32'h80000011};
    ta[4] = 32'h7F234123; tb[4] = 32'h0A000000; te[4] = {1'b1, 32'h89234123};
    ta[5] = 32'hFFFFFFFF; tb[5] = 32'hFFFFFFFF; te[5] = {1'b0, 32'hFFFFFFFE};
    ta[6] = 32'hFFFFFFFF; tb[6] = 32'h00000001; te[6] = {1'b0, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      sbq.push_back(te[i]);
      drive(ta[i], tb[i], 1'b1);
      exp = sbq.pop_front();
      tests++;
      if ({overflow, S} !== exp) begin
        fails++;
        $display("FAIL directed[%0d] %h+%h: got S=%h ovf=%b, want S=%h ovf=%b",
                 i, ta[i], tb[i], S, overflow, exp[31:0], exp[32]);
      end
    end
  endtask

  task automatic test_reset_release;
    logic [32:0] exp;
    sbq.push_back(33'd0);
    drive(32'h7FFFFFFF, 32'h00000001, 1'b0);
    exp = sbq.pop_front();
    tests++;
    if ({overflow, S} !== exp) begin
      fails++;
      $display("FAIL reset_hold: got S=%h ovf=%b, want S=%h ovf=%b",
               S, overflow, exp[31:0], exp[32]);
    end
    sbq.push_back({1'b1, 32'h80000000});
    drive(32'h7FFFFFFF, 32'h00000001, 1'b1);
    exp = sbq.pop_front();
    tests++;
    if ({overflow, S} !== exp) begin
      fails++;
      $display("FAIL reset_release: got S=%h ovf=%b, want S=%h ovf=%b",
               S, overflow, exp[31:0], exp[32]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
    logic [32:0] exp;
    int          nfail_here;
    nfail_here = 0;
    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h7FFFFFFF;
        1: b = 32'h80000000;
        2: b = ~a;
        3: b = -a;
        default: ;
      endcase
      r = (i % 613 == 300) ? 1'b0 : 1'b1;
      sbq.push_back(r ? model(a, b) : 33'd0);
      drive(a, b, r);
      exp = sbq.pop_front();
      tests++;
      if ({overflow, S} !== exp) begin
        fails++;
        nfail_here++;
        if (nfail_here <= 10)
          $display("FAIL random[%0d] %h+%h rst_n=%b: got S=%h ovf=%b, want S=%h ovf=%b",
                   i, a, b, r, S, overflow, exp[31:0], exp[32]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    A     = '0;
    B     = '0;
    test_reset();
    test_directed();
    test_reset_release();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
